// File: rtl/noise_floor_tracker.sv
// noise_floor_tracker: sliding-window mean of offset-binary samples plus a saturating detection threshold.
// Optional outlier clip in TRACK when NFE_OUTLIER_CLIP_EN is defined.
module noise_floor_tracker #(
    parameter int W           = 16,
    parameter int LOG2_N      = 4,
    parameter int CLIP_MARGIN = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din_valid_i,
    input  logic [W-1:0] din_i,
    input  logic         freeze_i,
    input  logic         flush_i,
    input  logic [W-1:0] thr_offset_i,
    output logic [W-1:0] mean_o,
    output logic [W-1:0] threshold_o,
    output logic         mean_valid_o,
    output logic         dout_valid_o,
    output logic         thr_sat_o,
    output logic         clip_hit_o
);
    localparam int N  = 1 << LOG2_N;
    localparam int SW = W + LOG2_N;
    typedef enum logic {FILL, TRACK} state_t;
    state_t                state_q, state_d;
    logic [N-1:0][W-1:0]   taps_q;
    logic [SW-1:0]         sum_q, sum_d;
    logic [LOG2_N:0]       cnt_q, cnt_d;
    logic [W-1:0]          mean_q, mean_d, thr_q, thr_d, u, enter;
    logic [W:0]            thr_sum;
    logic                  dv_q, sat_q, clip_q, accept, clip;
`ifdef NFE_OUTLIER_CLIP_EN
    logic [W:0]            lim;
`else
    logic                  unused_margin;
    assign unused_margin = ^CLIP_MARGIN;
`endif
    always_comb begin
        u      = {~din_i[W-1], din_i[W-2:0]};
        accept = din_valid_i && !freeze_i && !flush_i;
`ifdef NFE_OUTLIER_CLIP_EN
        lim    = {1'b0, mean_q} + (W+1)'(CLIP_MARGIN);
        clip   = (state_q == TRACK) && ({1'b0, u} > lim);
        enter  = clip ? (lim[W] ? '1 : lim[W-1:0]) : u;
`else
        clip   = 1'b0;
        enter  = u;
`endif
        // the oldest tap leaves as the new value enters, so the sum never exceeds N*(2^W-1)
        sum_d   = sum_q + SW'(enter) - SW'(taps_q[N-1]);
        mean_d  = sum_d[SW-1:LOG2_N];
        thr_sum = {1'b0, mean_d} + {1'b0, thr_offset_i};
        thr_d   = thr_sum[W] ? '1 : thr_sum[W-1:0];
        cnt_d   = cnt_q + (LOG2_N+1)'(state_q == FILL);
        state_d = flush_i ? FILL
                : (accept && state_q == FILL && cnt_q == (LOG2_N+1)'(N-1)) ? TRACK
                : state_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            taps_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            mean_q  <= '0;
            thr_q   <= '0;
            dv_q    <= 1'b0;
            sat_q   <= 1'b0;
            clip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dv_q    <= accept;
            clip_q  <= accept && clip;
            if (flush_i) begin
                taps_q <= '0;
                sum_q  <= '0;
                cnt_q  <= '0;
                sat_q  <= 1'b0;
            end else if (accept) begin
                taps_q <= {taps_q[N-2:0], enter};
                sum_q  <= sum_d;
                cnt_q  <= cnt_d;
                mean_q <= mean_d;
                thr_q  <= thr_d;
                sat_q  <= thr_sum[W];
            end
        end
    end
    assign mean_o       = mean_q;
    assign threshold_o  = thr_q;
    assign mean_valid_o = state_q == TRACK;
    assign dout_valid_o = dv_q;
    assign thr_sat_o    = sat_q;
    assign clip_hit_o   = clip_q;
endmodule

// File: tb/tb_noise_floor_tracker.sv
// tb_noise_floor_tracker: table vectors, directed corner sequences and random stimulus against a window-queue model.
module tb_noise_floor_tracker;
    localparam int N    = 16;
    localparam int CLIP = 4096;
    logic        clk = 1'b0, rst = 1'b0, din_valid_i = 1'b0, freeze_i = 1'b0, flush_i = 1'b0;
    logic [15:0] din_i = '0, thr_offset_i = '0;
    logic [15:0] mean_o, threshold_o;
    logic        mean_valid_o, dout_valid_o, thr_sat_o, clip_hit_o;
    int          n_chk = 0, n_fail = 0;
    int unsigned win[$];
    int unsigned m_mean = 0, m_thr = 0;
    bit          m_mv = 0, m_dv = 0, m_sat = 0, m_clip = 0;
    int          m_cnt = 0;
    typedef struct {
        bit          v, fz, fl;
        logic [15:0] d, off, e_mean, e_thr;
        bit          e_mv, e_dv, e_sat;
    } vec_t;
    vec_t tbl[9];

    noise_floor_tracker #(.W(16), .LOG2_N(4), .CLIP_MARGIN(CLIP)) dut (
        .clk(clk), .rst(rst), .din_valid_i(din_valid_i), .din_i(din_i),
        .freeze_i(freeze_i), .flush_i(flush_i), .thr_offset_i(thr_offset_i),
        .mean_o(mean_o), .threshold_o(threshold_o), .mean_valid_o(mean_valid_o),
        .dout_valid_o(dout_valid_o), .thr_sat_o(thr_sat_o), .clip_hit_o(clip_hit_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_window();
        win.delete();
        for (int i = 0; i < N; i++) win.push_back(0);
        m_cnt = 0; m_mv = 0;
    endtask

    task automatic model(input bit rn, v, fz, fl, input int unsigned d, off);
        int unsigned u, e, s, t;
        if (!rn) begin
            clear_window();
            m_mean = 0; m_thr = 0; m_sat = 0; m_dv = 0; m_clip = 0;
        end else if (fl) begin
            clear_window();
            m_sat = 0; m_dv = 0; m_clip = 0;
        end else if (v && !fz) begin
            u = d ^ 32'h8000;
            e = u;
            m_clip = 0;
`ifdef NFE_OUTLIER_CLIP_EN
            if (m_mv && u > m_mean + CLIP) begin
                e = (m_mean + CLIP > 65535) ? 65535 : m_mean + CLIP;
                m_clip = 1;
            end
`endif
            win.push_front(e);
            void'(win.pop_back());
            s = 0;
            foreach (win[i]) s += win[i];
            m_mean = s / N;
            t = m_mean + off;
            m_sat = t > 65535;
            m_thr = m_sat ? 65535 : t;
            if (!m_mv) begin
                m_cnt++;
                if (m_cnt == N) m_mv = 1;
            end
            m_dv = 1;
        end else begin
            m_dv = 0; m_clip = 0;
        end
    endtask

    task automatic step(input bit rn, v, fz, fl, input logic [15:0] d, off);
        rst = rn; din_valid_i = v; freeze_i = fz; flush_i = fl; din_i = d; thr_offset_i = off;
        model(rn, v, fz, fl, d, off);
        @(posedge clk);
        #1;
        check("model mean", mean_o, m_mean);
        check("model threshold", threshold_o, m_thr);
        check("model mean_valid", mean_valid_o, m_mv);
        check("model dout_valid", dout_valid_o, m_dv);
        if (m_dv) check("model thr_sat", thr_sat_o, m_sat);
        check("model clip_hit", clip_hit_o, m_clip);
    endtask

    initial begin
        tbl[0] = '{1, 0, 0, 16'h0000, 16'd100,   16'd2048, 16'd2148,  0, 1, 0};
        tbl[1] = '{0, 0, 0, 16'h0000, 16'd100,   16'd2048, 16'd2148,  0, 0, 0};
        tbl[2] = '{1, 1, 0, 16'h7FFF, 16'd100,   16'd2048, 16'd2148,  0, 0, 0};
        tbl[3] = '{1, 0, 0, 16'h7FFF, 16'd100,   16'd6143, 16'd6243,  0, 1, 0};
        tbl[4] = '{1, 0, 1, 16'h7FFF, 16'd100,   16'd6143, 16'd6243,  0, 0, 0};
        tbl[5] = '{1, 0, 0, 16'h0000, 16'd100,   16'd2048, 16'd2148,  0, 1, 0};
        tbl[6] = '{1, 0, 0, 16'h8000, 16'd100,   16'd2048, 16'd2148,  0, 1, 0};
        tbl[7] = '{1, 0, 0, 16'h7FFF, 16'hFFFF,  16'd6143, 16'd65535, 0, 1, 1};
        tbl[8] = '{1, 1, 1, 16'h7FFF, 16'hFFFF,  16'd6143, 16'd65535, 0, 0, 0};
        clear_window();
        step(0, 0, 0, 0, 16'h0, 16'd100);
        step(0, 1, 0, 0, 16'h1234, 16'd100);
        check("reset mean", mean_o, 0);
        check("reset threshold", threshold_o, 0);
        check("reset mean_valid", mean_valid_o, 0);

        foreach (tbl[i]) begin
            step(1, tbl[i].v, tbl[i].fz, tbl[i].fl, tbl[i].d, tbl[i].off);
            check($sformatf("vec%0d mean", i), mean_o, tbl[i].e_mean);
            check($sformatf("vec%0d threshold", i), threshold_o, tbl[i].e_thr);
            check($sformatf("vec%0d mean_valid", i), mean_valid_o, tbl[i].e_mv);
            check($sformatf("vec%0d dout_valid", i), dout_valid_o, tbl[i].e_dv);
            if (tbl[i].e_dv) check($sformatf("vec%0d thr_sat", i), thr_sat_o, tbl[i].e_sat);
        end

        step(0, 0, 0, 0, 16'h0, 16'd100);
        for (int i = 1; i <= N; i++) begin
            step(1, 1, 0, 0, 16'h0000, 16'd100);
            if (i == 1) begin
                check("fill1 mean", mean_o, 2048);
                check("fill1 mean_valid", mean_valid_o, 0);
            end
            if (i == N - 1) check("fill15 mean_valid", mean_valid_o, 0);
        end
        check("fill16 mean", mean_o, 32768);
        check("fill16 mean_valid", mean_valid_o, 1);
        check("fill16 dout_valid", dout_valid_o, 1);

        for (int i = 0; i < N; i++) step(1, 1, 0, 0, 16'h8000, 16'd100);
        check("low mean", mean_o, 0);
        check("low threshold", threshold_o, 100);
        check("low thr_sat", thr_sat_o, 0);

        for (int i = 0; i < N; i++) step(1, 1, 0, 0, 16'h7FFF, 16'd100);
        check("high mean", mean_o, 65535);
        check("high threshold", threshold_o, 65535);
        check("high thr_sat", thr_sat_o, 1);

        for (int i = 0; i < N; i++) step(1, 1, 0, 0, 16'h8000 + 16'(i * 1000), 16'd50);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 1, 0, 16'h7FFF, 16'd50);
            check("freeze dout_valid", dout_valid_o, 0);
        end
        step(1, 1, 0, 0, 16'h8000, 16'd50);

        step(1, 1, 0, 1, 16'h7FFF, 16'd50);
        check("flush mean_valid", mean_valid_o, 0);
        check("flush dout_valid", dout_valid_o, 0);
        step(1, 1, 0, 0, 16'h0000, 16'd50);
        check("post-flush mean", mean_o, 2048);
        step(0, 1, 0, 0, 16'h7FFF, 16'd50);
        check("rst mean", mean_o, 0);
        check("rst threshold", threshold_o, 0);
        check("rst dout_valid", dout_valid_o, 0);
        check("rst mean_valid", mean_valid_o, 0);

        for (int i = 0; i < N; i++) step(1, 1, 0, 0, 16'h0000, 16'd0);
        step(1, 1, 0, 0, 16'h7FFF, 16'd0);
`ifdef NFE_OUTLIER_CLIP_EN
        check("clip clip_hit", clip_hit_o, 1);
        check("clip mean", mean_o, 33024);
`else
        check("noclip clip_hit", clip_hit_o, 0);
        check("noclip mean", mean_o, 34815);
`endif

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199) != 0, $urandom_range(3) != 0, $urandom_range(7) == 0,
                 $urandom_range(63) == 0, 16'($urandom),
                 $urandom_range(3) == 0 ? 16'($urandom) : 16'($urandom_range(511)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
